// File: rtl/display_scan_ctl_pkg.sv
// display_scan_ctl_pkg: shared BCD width, calculator state encodings and decoder blank code
package display_scan_ctl_pkg;
  localparam int BCD_BIT_WIDTH = 4;
  typedef enum logic [1:0] {
    OP_A_IN    = 2'd0,
    OP_B_IN    = 2'd1,
    RESULT_OUT = 2'd2
  } calc_state_e;
  localparam logic [BCD_BIT_WIDTH-1:0] DIGIT_BLANK_CODE = 4'hF;
endpackage

// File: rtl/display_scan_ctl_prescaler.sv
// scan_prescaler: modulo-N counter that pulses tick on the enabled cycle where it wraps
module scan_prescaler #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(N - 1);
  // count enabled cycles 0..N-1 and wrap on tick
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_scan_ctl.sv
// display_scan_ctl: tear-free frame latch and time-multiplexed BCD digit scan; DISPLAY_BLINK_EN adds edited-operand blink
module display_scan_ctl
  import display_scan_ctl_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BCD_W     = BCD_BIT_WIDTH,
  parameter int SCAN_DIV  = 1024,
  parameter int BLINK_DIV = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  state,
  input  logic [DIGITS/2*BCD_W-1:0]   op_a,
  input  logic [DIGITS/2*BCD_W-1:0]   op_b,
  input  logic [DIGITS*BCD_W-1:0]     result,
  output logic [BCD_W-1:0]            bcd_out,
  output logic                        blank,
  output logic [DIGITS-1:0]           digit_en_n
);
  localparam int H  = DIGITS / 2;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  if (DIGITS < 2 || DIGITS % 2 != 0 || SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("display_scan_ctl: illegal parameter set");
  end
  logic                           tick, boundary, blink, seen;
  logic [IW-1:0]                  idx;
  logic [DIGITS-1:0][BCD_W-1:0]   frame_digit, map_digit;
  logic [DIGITS-1:0]              frame_blank, map_blank;
  logic [DIGITS*BCD_W-1:0]        src;
  scan_prescaler #(.N(SCAN_DIV)) u_scan (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (tick)
  );
  assign boundary = tick && idx == IW'(DIGITS - 1);
`ifdef DISPLAY_BLINK_EN
  logic blink_tick;
  scan_prescaler #(.N(BLINK_DIV)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .en   (boundary),
    .tick (blink_tick)
  );
  // blink phase flips every BLINK_DIV frame boundaries, independent of calculator state
  always_ff @(posedge clk or posedge rst)
    if (rst) blink <= 1'b0;
    else if (blink_tick) blink <= ~blink;
`else
  assign blink = 1'b0;
`endif
  // map calculator state to a candidate frame; leftmost position takes the top slice
  always_comb begin
    src = state == OP_A_IN    ? {op_a, (H*BCD_W)'(0)} :
          state == OP_B_IN    ? {op_a, op_b} :
          state == RESULT_OUT ? result : '0;
    map_digit = '0;
    map_blank = '0;
    seen      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      map_digit[i] = src[(DIGITS-1-i)*BCD_W +: BCD_W];
      seen         = seen | (map_digit[i] != '0);
      map_blank[i] = state == RESULT_OUT ? (!seen && i != DIGITS - 1) :
                     state == OP_A_IN    ? (blink && i < H) :
                     state == OP_B_IN    ? (blink && i >= H) : 1'b1;
      if (map_blank[i]) map_digit[i] = '0;
    end
  end
  // scan index advances per tick; the frame is only replaced when the scan wraps
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx         <= '0;
      frame_digit <= '0;
      frame_blank <= '1;
    end else begin
      if (tick) idx <= boundary ? '0 : idx + 1'b1;
      if (boundary) begin
        frame_digit <= map_digit;
        frame_blank <= map_blank;
      end
    end
  assign bcd_out    = frame_digit[idx];
  assign blank      = frame_blank[idx];
  assign digit_en_n = ~(DIGITS'(1) << idx);
endmodule

// File: doc/display_scan_ctl.md
Name: display_scan_ctl

Overview:
- Parametrised, registered successor to the combinational digit-select mux.
- Chooses operand or result BCD digits according to the calculator state and latches a full frame only at frame boundaries, so the display never tears.
- Time-multiplexes the frame onto one shared BCD bus with a one-hot active-low digit enable.
- Blanks leading zeros in results; sits between the calculator core and the BCD-to-7-seg decoder.

Parameters:
- DIGITS, 4: digits on the display; must be even and >= 2. Each operand is DIGITS/2 digits.
- BCD_W, 4: bits per digit; matches the shared BCD_BIT_WIDTH constant.
- SCAN_DIV, 1024: clk cycles per digit slot; must be >= 1.
- BLINK_DIV, 64: frames per blink half-period; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- state  in  2  calculator state (OP_A_IN, OP_B_IN, RESULT_OUT; encoding 3 unused)
- op_a  in  DIGITS/2*BCD_W  operand A digits, most significant digit in the top slice
- op_b  in  DIGITS/2*BCD_W  operand B digits, same packing as op_a
- result  in  DIGITS*BCD_W  result digits, same packing
- bcd_out  out  BCD_W  digit value for the currently selected position
- blank  out  1  1 = decoder must drive all segments off
- digit_en_n  out  DIGITS  one-hot, active-low; bit 0 = leftmost (most significant) position

Behaviour:
- Reset values: prescaler=0, idx=0, frame digits=0, frame blank bits all 1.
  - Outputs after reset: bcd_out=0, blank=1, digit_en_n = all ones except bit0 = 0.
- Prescaler: counts 0..SCAN_DIV-1 and asserts tick on SCAN_DIV-1, then wraps to 0.
  - On tick: idx advances by 1; idx wraps from DIGITS-1 to 0.
  - A tick that wraps idx is a frame boundary.
- Frame load: on a frame boundary the frame register loads the combinational mapping. Position 0 is leftmost.
  - OP_A_IN: positions 0..D/2-1 = op_a (MSD first); remaining positions = 0, not blanked.
  - OP_B_IN: positions 0..D/2-1 = op_a; positions D/2..D-1 = op_b.
  - RESULT_OUT: positions 0..D-1 = result (MSD first), with leading-zero blanking.
    - Every zero left of the first nonzero digit is blanked.
    - Position D-1 is never blanked, so an all-zero result shows a single "0".
  - state=3: all positions blank, digits=0.
- Input changes between frame boundaries are ignored.
  - Worst-case latency from an input change to display = 2*DIGITS*SCAN_DIV cycles.
- Outputs are registered, with no combinational path from inputs:
  - bcd_out and blank = frame entry at idx.
  - digit_en_n = ~(1<<idx).
  - Outputs update on the same edge as idx.
- Reset asserted mid-frame returns all registers to reset values immediately; no partial frame is retained.
- SCAN_DIV=1: a tick occurs every cycle, so idx advances every clk.

Optional Feature:
- Macro: DISPLAY_BLINK_EN.
- Defined:
  - A blink register toggles every BLINK_DIV frame boundaries; reset value 0 = visible.
  - While blink=1, the operand being edited is forced blank: op_a positions in OP_A_IN, op_b positions in OP_B_IN.
  - RESULT_OUT and state=3 are unaffected.
  - The blink counter runs continuously and is not cleared on state change.
- Undefined: no blink register or counter is synthesised; the display is steady.

Decomposition:
- Shared global package/include holds:
  - BCD_BIT_WIDTH.
  - State encodings OP_A_IN=2'd0, OP_B_IN=2'd1, RESULT_OUT=2'd2.
  - DIGIT_BLANK_CODE=4'hF, which the decoder maps to all segments off.
- One natural sub-module: scan_prescaler, a parametrised modulo-N tick generator.
  - Reused for both the scan tick and the blink counter.
- Frame mapping and leading-zero logic stay inline.

Test Plan:
All scenarios use DIGITS=4 and SCAN_DIV=2 unless stated.
1. Reset, release, hold 20 cycles with state=RESULT_OUT and result=16'h0000 -> after the first frame boundary: blank=1 at idx 0..2; idx 3 shows bcd_out=0, blank=0; digit_en_n cycles 1110, 1101, 1011, 0111 every 2 clks.
2. state=OP_B_IN, op_a=8'h12, op_b=8'h34 -> frame shows 1,2,3,4, none blanked.
3. state=RESULT_OUT, result=16'h0405 -> positions show blank, 4, 0, 5; the interior zero is not blanked.
4. Change result from 16'h1234 to 16'h9999 at idx=1 -> positions 2 and 3 in the current frame still show 3 and 4; the next full frame shows 9999.
5. Assert rst while idx=2 -> outputs return to reset values on the same cycle: digit_en_n=1110, blank=1.
6. With DISPLAY_BLINK_EN, BLINK_DIV=2, state=OP_A_IN, op_a=8'h56 -> positions 0..1 alternate between visible (5, 6) and blanked every 2 frames; positions 2..3 steadily show 0.
